mac_rx_monitor: RTL and testbench

//  Parametrised RX frame monitor on the MAC byte stream from the rgmii receiver.
//  - Computes CRC32 per frame and checks the residue; classifies frames by length.
//  - Keeps saturating statistics counters.
//  - Drives a multiplexed hex seven-segment display with the counter chosen by sel.
//  - Successor to the raw stream-to-display tap: board top instantiates it

---
 rtl/mac_rx_monitor_if.sv | 26 ++
 rtl/mac_rx_monitor.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mac_rx_monitor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_monitor_if.sv
// MAC RX byte-stream bundle between the rgmii receiver and its consumers.
// The receiver side drives every signal; there is no ready/backpressure path.
// Framing is marked by startofpacket/endofpacket, qualified by valid.
interface mac_rx_monitor_if;
    logic       startofpacket;
    logic       endofpacket;
    logic       valid;
    logic [7:0] data;
    logic       error;

    modport master (
        output startofpacket,
        output endofpacket,
        output valid,
        output data,
        output error
    );

    modport slave (
        input startofpacket,
        input endofpacket,
        input valid,
        input data,
        input error
    );
endinterface

// File: rtl/mac_rx_monitor.sv
// Purpose: RX frame monitor - CRC32 residue check, length classing, saturating stats, hex 7-seg display.
// Latency: frame_done / frame_* registered 1 cycle after the eop beat; display shows a snapshot per digit rotation.
// Backpressure: none, every valid beat is consumed. Optional MAC_RX_MON_BYTES_EN adds byte and orphan counters.
module mac_rx_monitor #(
    parameter logic [31:0] P_RESIDUE      = 32'hC704DD7B,
    parameter int          CNT_W          = 32,
    parameter int          MIN_LEN        = 64,
    parameter int          MAX_LEN        = 1522,
    parameter int          REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                mac_clk,
    input  logic                mac_rst_n,
    mac_rx_monitor_if.slave     rx,
    input  logic [2:0]          sel,
    input  logic                clear,
    output logic                frame_done,
    output logic                frame_good,
    output logic                frame_crc_err,
    output logic [15:0]         frame_len,
    output logic [3:0]          seven_seg_en,
    output logic [7:0]          seven_seg_led
);

    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam int          RW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_IN_FRAME, ST_DROP} state_t;

    // Reflected CRC32, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Saturating add; inc is at most 2 (old frame closed by sop plus a same-beat sop&eop frame).
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W - 1){1'b0}}, inc};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    state_t        state, nxt_state;
    logic [31:0]   crc, nxt_crc;
    logic [15:0]   len, nxt_len, len_inc;
    logic          err_flag, nxt_err;
    logic          over_flag, nxt_over;
    logic          close_old, close_new;
    logic          byte_inc, orphan_inc;
    logic          new_err, new_over, new_runt, new_crcbad, new_good;

    logic [CNT_W-1:0] cnt_good, cnt_crc, cnt_err, cnt_runt, cnt_over;
    logic             any_sat;
    logic [15:0]      disp_val;

    // Per-beat frame tracking and classification of whichever frame closes on this beat.
    always_comb begin
        nxt_state  = state;
        nxt_crc    = crc;
        nxt_len    = len;
        nxt_err    = err_flag;
        nxt_over   = over_flag;
        close_old  = 1'b0;
        close_new  = 1'b0;
        byte_inc   = 1'b0;
        orphan_inc = 1'b0;
        len_inc    = (len == 16'hFFFF) ? len : len + 16'd1;
        if (rx.valid) begin
            if (rx.startofpacket) begin
                // A sop inside a frame closes the old one as errored; the new frame starts here.
                close_old = (state != ST_IDLE);
                byte_inc  = 1'b1;
                nxt_crc   = crc_byte(32'hFFFF_FFFF, rx.data);
                nxt_len   = 16'd1;
                nxt_err   = rx.error;
                nxt_over  = 1'b0;
                if (rx.endofpacket) begin
                    close_new = 1'b1;
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_state = ST_IN_FRAME;
                end
            end else begin
                case (state)
                    ST_IDLE: orphan_inc = 1'b1;
                    ST_IN_FRAME: begin
                        byte_inc = 1'b1;
                        nxt_len  = len_inc;
                        nxt_err  = err_flag | rx.error;
                        if (len >= MAX_LEN_W) begin
                            nxt_over  = 1'b1;
                            nxt_state = ST_DROP;
                        end else begin
                            nxt_crc = crc_byte(crc, rx.data);
                        end
                        if (rx.endofpacket) begin
                            close_new = 1'b1;
                            nxt_state = ST_IDLE;
                        end
                    end
                    default: begin
                        byte_inc = 1'b1;
                        nxt_len  = len_inc;
                        nxt_err  = err_flag | rx.error;
                        if (rx.endofpacket) begin
                            close_new = 1'b1;
                            nxt_state = ST_IDLE;
                        end
                    end
                endcase
            end
        end
        new_err    = nxt_err;
        new_over   = !nxt_err && nxt_over;
        new_runt   = !nxt_err && !nxt_over && (nxt_len < MIN_LEN_W);
        new_crcbad = !nxt_err && !nxt_over && !(nxt_len < MIN_LEN_W)
                     && (bitrev32(nxt_crc) != P_RESIDUE);
        new_good   = !nxt_err && !nxt_over && !(nxt_len < MIN_LEN_W)
                     && (bitrev32(nxt_crc) == P_RESIDUE);
    end

    // Frame FSM state and running CRC/length/flags.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state     <= ST_IDLE;
            crc       <= 32'hFFFF_FFFF;
            len       <= 16'd0;
            err_flag  <= 1'b0;
            over_flag <= 1'b0;
        end else begin
            state     <= nxt_state;
            crc       <= nxt_crc;
            len       <= nxt_len;
            err_flag  <= nxt_err;
            over_flag <= nxt_over;
        end
    end

    // Registered per-frame result; a same-beat new frame takes precedence over the closed old one.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            frame_done    <= 1'b0;
            frame_good    <= 1'b0;
            frame_crc_err <= 1'b0;
            frame_len     <= 16'd0;
        end else begin
            frame_done <= close_old | close_new;
            if (close_new) begin
                frame_good    <= new_good;
                frame_crc_err <= new_crcbad;
            end else if (close_old) begin
                frame_good    <= 1'b0;
                frame_crc_err <= 1'b0;
            end
            if (clear)          frame_len <= 16'd0;
            else if (close_new) frame_len <= nxt_len;
            else if (close_old) frame_len <= len;
        end
    end

    // Class counters; clear beats any same-cycle increment.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            cnt_good <= '0;
            cnt_crc  <= '0;
            cnt_err  <= '0;
            cnt_runt <= '0;
            cnt_over <= '0;
        end else if (clear) begin
            cnt_good <= '0;
            cnt_crc  <= '0;
            cnt_err  <= '0;
            cnt_runt <= '0;
            cnt_over <= '0;
        end else begin
            cnt_good <= sat_add(cnt_good, {1'b0, close_new & new_good});
            cnt_crc  <= sat_add(cnt_crc,  {1'b0, close_new & new_crcbad});
            cnt_err  <= sat_add(cnt_err,  {1'b0, close_old} + {1'b0, close_new & new_err});
            cnt_runt <= sat_add(cnt_runt, {1'b0, close_new & new_runt});
            cnt_over <= sat_add(cnt_over, {1'b0, close_new & new_over});
        end
    end

`ifdef MAC_RX_MON_BYTES_EN
    logic [CNT_W-1:0] cnt_bytes, cnt_orphan;

    // Byte and orphan counters.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            cnt_bytes  <= '0;
            cnt_orphan <= '0;
        end else if (clear) begin
            cnt_bytes  <= '0;
            cnt_orphan <= '0;
        end else begin
            cnt_bytes  <= sat_add(cnt_bytes,  {1'b0, byte_inc});
            cnt_orphan <= sat_add(cnt_orphan, {1'b0, orphan_inc});
        end
    end

    // Saturation flag and display source select.
    always_comb begin
        any_sat = (&cnt_good) | (&cnt_crc) | (&cnt_err) | (&cnt_runt) | (&cnt_over)
                  | (&cnt_bytes) | (&cnt_orphan);
        case (sel)
            3'd0:    disp_val = cnt_good[15:0];
            3'd1:    disp_val = cnt_crc[15:0];
            3'd2:    disp_val = cnt_err[15:0];
            3'd3:    disp_val = cnt_runt[15:0];
            3'd4:    disp_val = cnt_over[15:0];
            3'd5:    disp_val = cnt_orphan[15:0];
            3'd6:    disp_val = cnt_bytes[15:0];
            default: disp_val = frame_len;
        endcase
    end
`else
    logic unused_inc;
    assign unused_inc = byte_inc ^ orphan_inc;

    // Saturation flag and display source select; byte/orphan slots read as zero.
    always_comb begin
        any_sat = (&cnt_good) | (&cnt_crc) | (&cnt_err) | (&cnt_runt) | (&cnt_over);
        case (sel)
            3'd0:    disp_val = cnt_good[15:0];
            3'd1:    disp_val = cnt_crc[15:0];
            3'd2:    disp_val = cnt_err[15:0];
            3'd3:    disp_val = cnt_runt[15:0];
            3'd4:    disp_val = cnt_over[15:0];
            3'd7:    disp_val = frame_len;
            default: disp_val = 16'd0;
        endcase
    end
`endif

    logic [RW-1:0] refresh;
    logic [1:0]    digit;
    logic [15:0]   snap;
    logic          ref_tc;
    logic [3:0]    cur_nib;

    assign ref_tc  = (refresh == REF_LAST);
    assign cur_nib = snap[{digit, 2'b00} +: 4];

    // Digit multiplexing; value is captured only as the index wraps so all 4 digits agree.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            refresh       <= '0;
            digit         <= 2'd0;
            snap          <= 16'd0;
            seven_seg_en  <= SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
            seven_seg_led <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
        end else begin
            if (ref_tc) begin
                refresh <= '0;
                digit   <= digit + 2'd1;
                if (digit == 2'd3) snap <= disp_val;
            end else begin
                refresh <= refresh + 1'b1;
            end
            seven_seg_en  <= (4'b0001 << digit) ^ {4{SEG_ACTIVE_LOW}};
            seven_seg_led <= {(digit == 2'd0) && any_sat, hex7(cur_nib)} ^ {8{SEG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_mac_rx_monitor.sv
// Directed bench for mac_rx_monitor: table of frames plus multi-cycle corner sequences.
module tb_mac_rx_monitor;

    logic        mac_clk = 1'b0;
    logic        mac_rst_n = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        clear = 1'b0;
    logic        frame_done, frame_good, frame_crc_err;
    logic [15:0] frame_len;
    logic [3:0]  seven_seg_en;
    logic [7:0]  seven_seg_led;

    mac_rx_monitor_if rx_if ();

    mac_rx_monitor #(
        .CNT_W       (16),
        .REFRESH_DIV (4)
    ) dut (
        .mac_clk       (mac_clk),
        .mac_rst_n     (mac_rst_n),
        .rx            (rx_if),
        .sel           (sel),
        .clear         (clear),
        .frame_done    (frame_done),
        .frame_good    (frame_good),
        .frame_crc_err (frame_crc_err),
        .frame_len     (frame_len),
        .seven_seg_en  (seven_seg_en),
        .seven_seg_led (seven_seg_led)
    );

    always #5 mac_clk = ~mac_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        good;
        logic        crc;
        logic [15:0] len;
    } done_t;
    done_t done_q[$];

    // Record every frame_done pulse away from the active edge.
    always @(negedge mac_clk) begin
        if (frame_done) done_q.push_back('{frame_good, frame_crc_err, frame_len});
    end

    typedef struct {
        string       name;
        int          len;
        int          flip;
        int          erri;
        logic [2:0]  sel;
        logic        good;
        logic        crc;
        logic [15:0] flen;
        logic [15:0] disp;
    } vec_t;
    vec_t vecs[9];

    logic [7:0] fbuf [0:1599];
    logic [6:0] hex_tab [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Payload pattern plus Ethernet FCS (final inversion, low byte first); optional bit flip.
    task automatic build_frame(input int len, input int flip);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len - 4; i++) begin
            fbuf[i] = 8'((i * 13 + 5) & 255);
            c = c ^ {24'd0, fbuf[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fbuf[len-4] = c[7:0];
        fbuf[len-3] = c[15:8];
        fbuf[len-2] = c[23:16];
        fbuf[len-1] = c[31:24];
        if (flip >= 0) fbuf[flip] = fbuf[flip] ^ 8'h01;
    endtask

    // Back-to-back beats from fbuf; leaves valid high on return.
    task automatic drive(input int n, input int erri, input bit eop_last);
        for (int i = 0; i < n; i++) begin
            rx_if.valid         = 1'b1;
            rx_if.startofpacket = (i == 0);
            rx_if.endofpacket   = eop_last && (i == n - 1);
            rx_if.error         = (i == erri);
            rx_if.data          = fbuf[i];
            @(posedge mac_clk); #1;
        end
    endtask

    task automatic idle(input int n);
        rx_if.valid         = 1'b0;
        rx_if.startofpacket = 1'b0;
        rx_if.endofpacket   = 1'b0;
        rx_if.error         = 1'b0;
        repeat (n) begin @(posedge mac_clk); #1; end
    endtask

    // Let the snapshot catch up with sel, then decode all four active-low digits.
    task automatic read_disp(input logic [2:0] s, output logic [15:0] v, output logic dp0, output logic ok);
        logic [3:0] seen, en_a;
        logic [7:0] seg_a;
        int k, n;
        seen = 4'h0; v = 16'h0; dp0 = 1'b0; ok = 1'b1;
        sel = s;
        repeat (40) @(posedge mac_clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge mac_clk);
            en_a  = ~seven_seg_en;
            seg_a = ~seven_seg_led;
            case (en_a)
                4'b0001: k = 0;
                4'b0010: k = 1;
                4'b0100: k = 2;
                4'b1000: k = 3;
                default: k = -1;
            endcase
            n = -1;
            for (int h = 0; h < 16; h++) if (seg_a[6:0] == hex_tab[h]) n = h;
            if (k < 0 || n < 0) ok = 1'b0;
            else begin
                v[k*4 +: 4] = 4'(n);
                seen[k] = 1'b1;
                if (k == 0) dp0 = seg_a[7];
            end
        end
        if (seen != 4'hF) ok = 1'b0;
        #1;
    endtask

    task automatic disp_chk(input string name, input logic [2:0] s, input logic [15:0] exp);
        logic [15:0] v;
        logic dp, ok;
        read_disp(s, v, dp, ok);
        chk({name, "_decode"}, {31'd0, ok}, 32'd1);
        chk(name, {16'd0, v}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] v;
        logic dp, ok;

        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0] = '{"good64",   64,   -1, -1, 3'd0, 1'b1, 1'b0, 16'd64,   16'h0001};
        vecs[1] = '{"crcbad64", 64,   10, -1, 3'd1, 1'b0, 1'b1, 16'd64,   16'h0001};
        vecs[2] = '{"runt40",   40,   -1, -1, 3'd3, 1'b0, 1'b0, 16'd40,   16'h0001};
        vecs[3] = '{"over1600", 1600, -1, -1, 3'd4, 1'b0, 1'b0, 16'd1600, 16'h0001};
        vecs[4] = '{"err64",    64,   -1, 20, 3'd2, 1'b0, 1'b0, 16'd64,   16'h0001};
        vecs[5] = '{"max1522",  1522, -1, -1, 3'd0, 1'b1, 1'b0, 16'd1522, 16'h0002};
        vecs[6] = '{"over1523", 1523, -1, -1, 3'd4, 1'b0, 1'b0, 16'd1523, 16'h0002};
        vecs[7] = '{"runt63",   63,   -1, -1, 3'd3, 1'b0, 1'b0, 16'd63,   16'h0002};
        vecs[8] = '{"len_disp", 64,   -1, -1, 3'd7, 1'b1, 1'b0, 16'd64,   16'h0040};

        idle(0);
        repeat (3) @(negedge mac_clk);
        chk("rst_en",   {28'd0, seven_seg_en}, 32'hF);
        chk("rst_led",  {24'd0, seven_seg_led}, 32'hFF);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_good", {31'd0, frame_good}, 32'd0);
        chk("rst_len",  {16'd0, frame_len}, 32'd0);
        @(posedge mac_clk); #1;
        mac_rst_n = 1'b1;
        idle(4);

        for (int t = 0; t < 9; t++) begin
            done_q.delete();
            build_frame(vecs[t].len, vecs[t].flip);
            drive(vecs[t].len, vecs[t].erri, 1'b1);
            chk({vecs[t].name, "_done_lat"}, {31'd0, frame_done}, 32'd1);
            idle(1);
            chk({vecs[t].name, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
            idle(3);
            chk({vecs[t].name, "_ndone"}, done_q.size(), 32'd1);
            chk({vecs[t].name, "_good"}, {31'd0, frame_good}, {31'd0, vecs[t].good});
            chk({vecs[t].name, "_crc"},  {31'd0, frame_crc_err}, {31'd0, vecs[t].crc});
            chk({vecs[t].name, "_len"},  {16'd0, frame_len}, {16'd0, vecs[t].flen});
            disp_chk({vecs[t].name, "_disp"}, vecs[t].sel, vecs[t].disp);
        end
        disp_chk("good_total", 3'd0, 16'h0003);
        disp_chk("crc_total",  3'd1, 16'h0001);
`ifndef MAC_RX_MON_BYTES_EN
        disp_chk("bytes_absent", 3'd6, 16'h0000);
`endif

        // Frame A cut by sop at byte 30, followed immediately by good frame B.
        done_q.delete();
        build_frame(64, -1);
        drive(30, -1, 1'b0);
        build_frame(64, -1);
        drive(64, -1, 1'b1);
        idle(4);
        chk("cut_ndone", done_q.size(), 32'd2);
        if (done_q.size() == 2) begin
            chk("cut_a_good", {31'd0, done_q[0].good}, 32'd0);
            chk("cut_a_len",  {16'd0, done_q[0].len}, 32'd30);
            chk("cut_b_good", {31'd0, done_q[1].good}, 32'd1);
            chk("cut_b_len",  {16'd0, done_q[1].len}, 32'd64);
        end
        disp_chk("cut_err", 3'd2, 16'h0002);
        disp_chk("cut_good", 3'd0, 16'h0004);

        // Reset in the middle of a frame: no done, counters cleared.
        done_q.delete();
        build_frame(64, -1);
        drive(20, -1, 1'b0);
        mac_rst_n = 1'b0;
        idle(2);
        chk("midrst_en", {28'd0, seven_seg_en}, 32'hF);
        mac_rst_n = 1'b1;
        idle(5);
        chk("midrst_ndone", done_q.size(), 32'd0);
        drive(64, -1, 1'b1);
        idle(2);
        chk("midrst_good", {31'd0, frame_good}, 32'd1);
        disp_chk("midrst_cnt", 3'd0, 16'h0001);

        // Saturate the 16-bit err counter with single-beat errored frames.
        rx_if.valid = 1'b1; rx_if.startofpacket = 1'b1; rx_if.endofpacket = 1'b1;
        rx_if.error = 1'b1; rx_if.data = 8'h00;
        repeat (65540) @(posedge mac_clk);
        #1;
        idle(2);
        read_disp(3'd2, v, dp, ok);
        chk("sat_decode", {31'd0, ok}, 32'd1);
        chk("sat_err", {16'd0, v}, 32'hFFFF);
        chk("sat_dp", {31'd0, dp}, 32'd1);

        // clear on the same beat as a closing frame.
        rx_if.valid = 1'b1; rx_if.startofpacket = 1'b1; rx_if.endofpacket = 1'b1;
        rx_if.error = 1'b1; clear = 1'b1;
        @(posedge mac_clk); #1;
        clear = 1'b0;
        chk("clr_done", {31'd0, frame_done}, 32'd1);
        chk("clr_len",  {16'd0, frame_len}, 32'd0);
        idle(2);
        read_disp(3'd2, v, dp, ok);
        chk("clr_decode", {31'd0, ok}, 32'd1);
        chk("clr_err", {16'd0, v}, 32'd0);
        chk("clr_dp", {31'd0, dp}, 32'd0);
        disp_chk("clr_good", 3'd0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
